uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Receive end of the 8N1 UART link, counterpart of the transmitter block.
- Samples the asynchronous serial line using an oversampled baud tick and validates the start bit.
- Majority-votes each bit and checks the stop bit.
- Presents each received byte on a valid/ready output holding register, with framing-error and overrun reporting, to downstream logic (host command parser / FIFO).

Parameters:
- OVERSAMPLE, 16, baud_tick pulses per bit period; even, ≥8.
- DATA_BITS, 8, data bits per frame, LSB first.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, synchronous, active-low.
- baud_tick  input  1  one-cycle pulse at baud×OVERSAMPLE (from BaudTickGen).
- rx  input  1  asynchronous serial line, idle high.
- data_out  output  DATA_BITS  received byte, stable while data_valid=1.
- data_valid  output  1  byte available; held until accepted.
- data_ready  input  1  consumer accepts byte when data_valid & data_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte completed while previous still unaccepted.
- rx_busy  output  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock clk_in; reset rst_in is synchronous and active-low.
- Reset (rst_in=0 at a clk_in edge) forces:
  - state=IDLE, synchronizer flops=1, counters=0, shift register=0;
  - data_out=0, data_valid=0, frame_err=0, overrun=0, rx_busy=0.
  - Reset mid-frame abandons the frame; no output is produced.
- Input sync: rx passes through 2 flops (reset value 1); all logic uses the synchronized rx_s, giving 2 cycles of latency.
- All state/counter advances occur only on cycles with baud_tick=1. sample_idx counts 0..OVERSAMPLE-1 within each bit and wraps to 0.
- Vote: rx_s is sampled at idx M-1, M, M+1 (M=OVERSAMPLE/2). bit = majority of the 3. The decision is taken at idx M+1.
- States:
  - IDLE: on tick with rx_s=0 → START, sample_idx=0 (this tick is idx 0).
  - START: at decision, bit=1 → IDLE (false start, no flags). bit=0 → continue. At idx OVERSAMPLE-1 → DATA, bit_cnt=0.
  - DATA: at decision, shift right and insert bit at MSB (LSB-first assembly). At idx OVERSAMPLE-1: bit_cnt==DATA_BITS-1 → STOP, else bit_cnt+1.
  - STOP: at decision, bit=1 → frame good, deliver byte, → IDLE immediately (resync half a bit early). bit=0 → frame_err pulse next cycle, byte discarded, → BREAK.
  - BREAK: on tick with rx_s=1 → IDLE. Long breaks produce exactly one frame_err.
- Delivery (cycle after the good-stop decision):
  - If data_valid=0, or data_valid & data_ready in that cycle: load data_out, data_valid=1.
  - Else: keep the old byte, drop the new one, pulse overrun.
- Accept: data_valid & data_ready clears data_valid next cycle unless a new byte loads the same cycle, in which case data_valid stays 1 with the new data.
- frame_err and overrun are never asserted together. Neither affects data_valid.
- Ticks absent: state holds indefinitely (no timeout).

Test Plan:
- OVERSAMPLE=16, tick every 4 clk; send 0xA5 (line 0,1,0,1,0,0,1,0,1,1), data_ready=1 → data_valid one cycle, data_out=0xA5, frame_err=0, overrun=0.
- Low glitch of 5 ticks on idle line → returns to IDLE; data_valid, frame_err, overrun stay 0; next 0x3C received correctly.
- 0x00 with stop bit low, then line held low 40 ticks, then high → exactly one frame_err pulse, no data_valid; following 0x55 received correctly.
- data_ready=0; send 0x11 then 0x22 → data_out=0x11 held valid, one overrun pulse; raise data_ready → 0x11 accepted, data_valid=0.
- Flip rx for one tick at idx 8 of data bit 3 while sending 0xF0 → majority corrects; data_out=0xF0.
- rst_in=0 for one cycle during data bit 4 of 0x7E → all outputs 0 next cycle; remainder of the frame is ignored or treated per the IDLE rules; subsequent clean 0x81 is received.

Source files
------------

// File: rtl/uart_receiver_if.sv
// ---------------------------------------------------------------------------
// uart_receiver_if
// Byte delivery channel from the UART receiver to its consumer.
//   data_out   : received byte, stable while data_valid is high
//   data_valid : byte available, held until accepted
//   data_ready : consumer accepts the byte when data_valid & data_ready
//   frame_err  : one-cycle pulse, stop bit sampled low
//   overrun    : one-cycle pulse, byte dropped because the previous one was
//                still unaccepted
// The receiver connects through the master modport and the consumer through
// the slave modport.
// ---------------------------------------------------------------------------
interface uart_receiver_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output data_out,
    output data_valid,
    output frame_err,
    output overrun,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    input  frame_err,
    input  overrun,
    output data_ready
  );
endinterface

// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
// Receive side of an 8N1 UART link. The asynchronous rx line is synchronized,
// sampled on an oversampled baud tick, every bit is majority-voted from three
// samples around mid-bit, and the stop bit is validated. Good bytes are
// offered on a valid/ready holding register; bad stop bits and dropped bytes
// are reported as one-cycle pulses.
// Ports:
//   clk_in    : system clock
//   rst_in    : synchronous active-low reset
//   baud_tick : one-cycle pulse at baud x OVERSAMPLE
//   rx        : asynchronous serial line, idle high
//   rx_busy   : high whenever the receiver is not idle
//   rx_bus    : byte delivery channel (data_out/data_valid/data_ready,
//               frame_err, overrun)
// ---------------------------------------------------------------------------
module uart_receiver #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            baud_tick,
  input  logic            rx,
  output logic            rx_busy,
  uart_receiver_if.master rx_bus
);

  localparam int IDX_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int MID   = OVERSAMPLE / 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  // Majority of three samples.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t               state_r;
  state_t               state_next_s;
  logic                 meta_r;
  logic                 rx_s_r;
  // Index of the tick that will be processed next within the current bit.
  logic [IDX_W-1:0]     sample_idx_r;
  logic [IDX_W-1:0]     idx_inc_s;
  logic [CNT_W-1:0]     bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 samp0_r;
  logic                 samp1_r;
  logic                 vote_s;
  logic                 decide_s;
  logic                 last_s;
  logic                 last_bit_s;
  logic                 good_stop_s;
  logic                 bad_stop_s;
  logic                 shift_en_s;
  logic                 rx_busy_next_s;
  logic                 pend_r;
  logic                 rx_busy_r;
  logic                 frame_err_r;
  logic                 overrun_r;
  logic                 data_valid_r;
  logic [DATA_BITS-1:0] data_out_r;

  assign rx_busy           = rx_busy_r;
  assign rx_bus.data_out   = data_out_r;
  assign rx_bus.data_valid = data_valid_r;
  assign rx_bus.frame_err  = frame_err_r;
  assign rx_bus.overrun    = overrun_r;

  // Two-flop synchronizer on the asynchronous serial line (idles high).
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      meta_r <= 1'b1;
      rx_s_r <= 1'b1;
    end else begin
      meta_r <= rx;
      rx_s_r <= meta_r;
    end
  end

  // Tick-position decode and the bit vote.
  always_comb begin
    decide_s   = baud_tick & (sample_idx_r == IDX_W'(MID + 1));
    last_s     = baud_tick & (sample_idx_r == IDX_W'(OVERSAMPLE - 1));
    last_bit_s = (bit_cnt_r == CNT_W'(DATA_BITS - 1));
    vote_s     = majority3(samp0_r, samp1_r, rx_s_r);
    if (sample_idx_r == IDX_W'(OVERSAMPLE - 1)) begin
      idx_inc_s = {IDX_W{1'b0}};
    end else begin
      idx_inc_s = sample_idx_r + IDX_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; nothing moves without a baud tick.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (baud_tick && !rx_s_r) begin
          state_next_s = ST_START;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        // A start bit that votes high is a glitch: drop back silently.
        if (decide_s && vote_s) begin
          state_next_s = ST_IDLE;
        end else if (last_s) begin
          state_next_s = ST_DATA;
        end else begin
          state_next_s = ST_START;
        end
      end
      ST_DATA: begin
        if (last_s && last_bit_s) begin
          state_next_s = ST_STOP;
        end else begin
          state_next_s = ST_DATA;
        end
      end
      ST_STOP: begin
        // A good stop returns to idle at mid-bit so the next start edge is
        // caught even if the transmitter runs slightly fast.
        if (decide_s) begin
          state_next_s = vote_s ? ST_IDLE : ST_BREAK;
        end else begin
          state_next_s = ST_STOP;
        end
      end
      ST_BREAK: begin
        if (baud_tick && rx_s_r) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_BREAK;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM output decode: stop verdicts, shift enable and next busy flag.
  always_comb begin
    good_stop_s    = 1'b0;
    bad_stop_s     = 1'b0;
    shift_en_s     = 1'b0;
    rx_busy_next_s = (state_next_s != ST_IDLE);
    case (state_r)
      ST_STOP: begin
        if (decide_s) begin
          good_stop_s = vote_s;
          bad_stop_s  = ~vote_s;
        end else begin
          good_stop_s = 1'b0;
          bad_stop_s  = 1'b0;
        end
      end
      ST_DATA: begin
        shift_en_s = decide_s;
      end
      default: begin
        shift_en_s = 1'b0;
      end
    endcase
  end

  // Sample index, vote samples, bit counter and shift register.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      sample_idx_r <= {IDX_W{1'b0}};
      bit_cnt_r    <= {CNT_W{1'b0}};
      shift_r      <= {DATA_BITS{1'b0}};
      samp0_r      <= 1'b0;
      samp1_r      <= 1'b0;
    end else if (baud_tick) begin
      // The tick that detects the start edge is index 0, so the next is 1.
      if (state_r == ST_IDLE) begin
        sample_idx_r <= (state_next_s == ST_START) ? IDX_W'(1) : {IDX_W{1'b0}};
      end else if ((state_next_s == ST_START) || (state_next_s == ST_DATA) ||
                   (state_next_s == ST_STOP)) begin
        sample_idx_r <= idx_inc_s;
      end else begin
        sample_idx_r <= {IDX_W{1'b0}};
      end

      if (sample_idx_r == IDX_W'(MID - 1)) begin
        samp0_r <= rx_s_r;
      end else begin
        samp0_r <= samp0_r;
      end
      if (sample_idx_r == IDX_W'(MID)) begin
        samp1_r <= rx_s_r;
      end else begin
        samp1_r <= samp1_r;
      end

      if ((state_r == ST_START) && (state_next_s == ST_DATA)) begin
        bit_cnt_r <= {CNT_W{1'b0}};
      end else if ((state_r == ST_DATA) && last_s && !last_bit_s) begin
        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end

      // LSB arrives first, so each new bit enters at the top.
      if (shift_en_s) begin
        shift_r <= {vote_s, shift_r[DATA_BITS-1:1]};
      end else begin
        shift_r <= shift_r;
      end
    end else begin
      sample_idx_r <= sample_idx_r;
      bit_cnt_r    <= bit_cnt_r;
      shift_r      <= shift_r;
      samp0_r      <= samp0_r;
      samp1_r      <= samp1_r;
    end
  end

  // Output holding register, handshake and status pulses.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      rx_busy_r    <= 1'b0;
      frame_err_r  <= 1'b0;
      overrun_r    <= 1'b0;
      pend_r       <= 1'b0;
      data_valid_r <= 1'b0;
      data_out_r   <= {DATA_BITS{1'b0}};
    end else begin
      rx_busy_r   <= rx_busy_next_s;
      frame_err_r <= bad_stop_s;
      pend_r      <= good_stop_s;
      overrun_r   <= 1'b0;
      // The byte is delivered the cycle after the good-stop decision; an
      // accept in that same cycle frees the register for the new byte.
      if (pend_r) begin
        if (!data_valid_r || rx_bus.data_ready) begin
          data_out_r   <= shift_r;
          data_valid_r <= 1'b1;
        end else begin
          overrun_r <= 1'b1;
        end
      end else if (data_valid_r && rx_bus.data_ready) begin
        data_valid_r <= 1'b0;
      end else begin
        data_valid_r <= data_valid_r;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver
// Directed-plus-random bench for uart_receiver (OVERSAMPLE=16, DATA_BITS=8,
// one baud tick every 4 clocks). Frames are driven bit by bit on rx; a
// transaction-level model predicts which bytes the consumer should accept
// and how many frame_err / overrun pulses should appear.
// ---------------------------------------------------------------------------
module tb_uart_receiver;

  logic clk = 1'b0;
  logic rst_in = 1'b0;
  logic baud_tick = 1'b0;
  logic rx = 1'b1;
  logic rx_busy;

  uart_receiver_if #(.DATA_BITS(8)) bus ();

  uart_receiver #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk_in    (clk),
    .rst_in    (rst_in),
    .baud_tick (baud_tick),
    .rx        (rx),
    .rx_busy   (rx_busy),
    .rx_bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Observed activity
  logic [7:0] got_q[$];
  int ferr_cycles = 0;
  int ovr_cycles = 0;
  int both_cycles = 0;
  int stab_err = 0;
  logic prev_v = 1'b0;
  logic prev_acc = 1'b0;
  logic [7:0] prev_d = 8'h00;

  // Reference model state
  logic [7:0] want_q[$];
  bit ready_lvl = 1'b0;
  bit m_valid = 1'b0;
  logic [7:0] m_byte = 8'h00;
  int want_ferr = 0;
  int want_ovr = 0;

  // Baud tick: one clock high out of every four.
  initial begin
    forever begin
      repeat (3) @(posedge clk);
      #1 baud_tick = 1'b1;
      @(posedge clk);
      #1 baud_tick = 1'b0;
    end
  end

  // Monitor: sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_in) begin
      if (bus.data_valid && bus.data_ready) got_q.push_back(bus.data_out);
      if (bus.frame_err) ferr_cycles++;
      if (bus.overrun) ovr_cycles++;
      if (bus.frame_err && bus.overrun) both_cycles++;
      if (prev_v && !prev_acc && bus.data_valid && (bus.data_out !== prev_d)) stab_err++;
      prev_v = bus.data_valid;
      prev_acc = bus.data_valid && bus.data_ready;
      prev_d = bus.data_out;
    end
  end

  // Watchdog
  initial begin
    #3ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic tick_wait(input int n);
    for (int k = 0; k < n; k++) begin
      do @(posedge clk); while (baud_tick !== 1'b1);
      #2;
    end
  endtask

  task automatic model_deliver(input logic [7:0] b);
    if (ready_lvl) want_q.push_back(b);
    else if (!m_valid) begin
      m_valid = 1'b1;
      m_byte = b;
    end else want_ovr++;
  endtask

  task automatic set_ready(input bit r);
    ready_lvl = r;
    bus.data_ready = r;
    if (r && m_valid) begin
      want_q.push_back(m_byte);
      m_valid = 1'b0;
    end
  endtask

  // One bit period; optionally flip the line for tick glitch_idx, or pulse
  // reset after rst_at ticks.
  task automatic send_bit(input logic v, input int glitch_idx, input int rst_at);
    rx = v;
    for (int t = 0; t < 16; t++) begin
      if (glitch_idx >= 0 && t == glitch_idx) rx = ~v;
      if (glitch_idx >= 0 && t == glitch_idx + 1) rx = v;
      if (t == rst_at) begin
        rst_in = 1'b0;
        @(posedge clk);
        #1;
        check("rst_data_out", bus.data_out, 32'h0);
        check("rst_data_valid", bus.data_valid, 32'h0);
        check("rst_frame_err", bus.frame_err, 32'h0);
        check("rst_overrun", bus.overrun, 32'h0);
        check("rst_rx_busy", rx_busy, 32'h0);
        rst_in = 1'b1;
      end
      tick_wait(1);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop, input int glitch_bit,
                            input int rst_bit);
    send_bit(1'b0, -1, -1);
    for (int i = 0; i < 8; i++)
      send_bit(b[i], (i == glitch_bit) ? 8 : -1, (i == rst_bit) ? 4 : -1);
    send_bit(stop, -1, -1);
    if (rst_bit < 0) begin
      if (stop) model_deliver(b);
      else want_ferr++;
    end
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    tick_wait(n * 16);
  endtask

  task automatic compare(input string tag);
    check({tag, "_count"}, got_q.size(), want_q.size());
    while (got_q.size() > 0 && want_q.size() > 0)
      check({tag, "_byte"}, got_q.pop_front(), want_q.pop_front());
    got_q.delete();
    want_q.delete();
  endtask

  initial begin
    logic [7:0] rb;
    bus.data_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_data_out", bus.data_out, 32'h0);
    check("reset_data_valid", bus.data_valid, 32'h0);
    check("reset_frame_err", bus.frame_err, 32'h0);
    check("reset_overrun", bus.overrun, 32'h0);
    check("reset_rx_busy", rx_busy, 32'h0);
    rst_in = 1'b1;

    // Basic reception: 0xA5 then random bytes, consumer always ready
    set_ready(1'b1);
    idle_bits(2);
    send_frame(8'hA5, 1'b1, -1, -1);
    idle_bits(1);
    for (int n = 0; n < 5; n++) begin
      rb = 8'($urandom_range(0, 255));
      send_frame(rb, 1'b1, -1, -1);
      idle_bits(1);
    end
    idle_bits(1);
    compare("basic");
    check("basic_frame_err", ferr_cycles, want_ferr);
    check("basic_overrun", ovr_cycles, want_ovr);

    // Short low glitch on the idle line is a false start
    rx = 1'b0;
    tick_wait(5);
    rx = 1'b1;
    check("glitch_busy", rx_busy, 32'h1);
    idle_bits(2);
    check("glitch_idle", rx_busy, 32'h0);
    check("glitch_no_byte", got_q.size(), 32'h0);
    send_frame(8'h3C, 1'b1, -1, -1);
    idle_bits(2);
    compare("after_glitch");
    check("glitch_frame_err", ferr_cycles, want_ferr);

    // Bad stop bit followed by a long break: one frame_err, no byte
    send_frame(8'h00, 1'b0, -1, -1);
    rx = 1'b0;
    tick_wait(40);
    check("break_busy", rx_busy, 32'h1);
    idle_bits(2);
    check("break_frame_err", ferr_cycles, want_ferr);
    check("break_no_byte", got_q.size(), 32'h0);
    send_frame(8'h55, 1'b1, -1, -1);
    idle_bits(2);
    compare("after_break");

    // Overrun: consumer stalled across two frames
    set_ready(1'b0);
    send_frame(8'h11, 1'b1, -1, -1);
    idle_bits(1);
    send_frame(8'h22, 1'b1, -1, -1);
    idle_bits(2);
    check("ovr_valid", bus.data_valid, {31'h0, m_valid});
    check("ovr_data", bus.data_out, {24'h0, m_byte});
    check("ovr_pulses", ovr_cycles, want_ovr);
    set_ready(1'b1);
    tick_wait(1);
    check("ovr_drained", bus.data_valid, 32'h0);
    compare("overrun");

    // Single-tick corruption at mid-bit is outvoted
    send_frame(8'hF0, 1'b1, 3, -1);
    idle_bits(2);
    compare("vote");

    // Reset during data bit 4 of 0x7E. The rest of that frame is
    // 1,1,1,0,stop: the low bit 7 looks like a fresh start bit and the
    // following idle-high line reads as 0xFF with a good stop.
    send_frame(8'h7E, 1'b1, -1, 4);
    idle_bits(12);
    model_deliver(8'hFF);
    compare("post_reset_tail");
    send_frame(8'h81, 1'b1, -1, -1);
    idle_bits(2);
    compare("post_reset");

    // Totals across the whole run
    check("total_frame_err", ferr_cycles, want_ferr);
    check("total_overrun", ovr_cycles, want_ovr);
    check("err_ovr_exclusive", both_cycles, 32'h0);
    check("data_stable", stab_err, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
